// File: rtl/fsm_light_monitor_pkg.sv
// Shared definitions for the traffic-light monitor: phase and error encodings,
// lamp bit order and default timing limits.
package fsm_light_monitor_pkg;

    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_RED    = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_ONEHOT    = 3'd1,
        ERR_SEQ       = 3'd2,
        ERR_YLW_SHORT = 3'd3,
        ERR_YLW_LONG  = 3'd4,
        ERR_RED_SHORT = 3'd5,
        ERR_NOCAR     = 3'd6,
        ERR_STARVE    = 3'd7
    } err_code_e;

    localparam int unsigned LAMP_GRN = 2;
    localparam int unsigned LAMP_YLW = 1;
    localparam int unsigned LAMP_RED = 0;

    localparam int unsigned DWELL_W = 8;
    localparam int unsigned WAIT_W  = 8;

    localparam int unsigned YLW_MIN_DEF     = 2;
    localparam int unsigned YLW_MAX_DEF     = 4;
    localparam int unsigned RED_MIN_DEF     = 5;
    localparam int unsigned CAR_TIMEOUT_DEF = 25;

    // Returns PH_SYNC for any pattern that is not exactly one lamp.
    function automatic phase_e lamp_to_phase(input logic [2:0] lamps);
        phase_e p;
        p = PH_SYNC;
        if (lamps == (3'(1) << LAMP_GRN)) p = PH_GREEN;
        if (lamps == (3'(1) << LAMP_YLW)) p = PH_YELLOW;
        if (lamps == (3'(1) << LAMP_RED)) p = PH_RED;
        return p;
    endfunction

    function automatic phase_e legal_next(input phase_e p);
        phase_e n;
        case (p)
            PH_GREEN:  n = PH_YELLOW;
            PH_YELLOW: n = PH_RED;
            PH_RED:    n = PH_GREEN;
            default:   n = PH_SYNC;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/fsm_light_monitor_if.sv
// Lamp/request inputs and monitor results; master is the controller/bench side,
// slave is the monitor.
interface fsm_light_monitor_if;
    logic       grn;
    logic       ylw;
    logic       red;
    logic       car;
    logic [1:0] phase;
    logic [7:0] dwell;
    logic       err;
    logic [2:0] err_code;
    logic       err_pulse;

    modport master (
        output grn, ylw, red, car,
        input  phase, dwell, err, err_code, err_pulse
    );

    modport slave (
        input  grn, ylw, red, car,
        output phase, dwell, err, err_code, err_pulse
    );
endinterface

// File: rtl/fsm_light_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear+inc together loads 1.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = inc_i ? WIDTH'(1) : '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/fsm_light_monitor.sv
// Passive checker on traffic-light lamp drives: tracks phase and dwell, and
// reports pattern, sequence, dwell and car-service violations.
module fsm_light_monitor
    import fsm_light_monitor_pkg::*;
#(
    parameter int unsigned YLW_MIN     = YLW_MIN_DEF,
    parameter int unsigned YLW_MAX     = YLW_MAX_DEF,
    parameter int unsigned RED_MIN     = RED_MIN_DEF,
    parameter int unsigned CAR_TIMEOUT = CAR_TIMEOUT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fsm_light_monitor_if.slave    mon
);
    localparam logic [DWELL_W-1:0] YLW_MIN_C  = DWELL_W'(YLW_MIN);
    localparam logic [DWELL_W-1:0] YLW_MAX_C  = DWELL_W'(YLW_MAX);
    localparam logic [DWELL_W-1:0] RED_MIN_C  = DWELL_W'(RED_MIN);
    localparam logic [WAIT_W-1:0]  STARVE_AT  = WAIT_W'(CAR_TIMEOUT - 1);

    phase_e            phase_q, phase_d;
    logic              checked_q, checked_d;
    logic              car_req_q, car_req_d;
    logic              err_q, err_d;
    err_code_e         err_code_q, err_code_d;
    logic              err_pulse_q, err_pulse_d;

    logic [DWELL_W-1:0] dwell_q;
    logic [WAIT_W-1:0]  wait_q;
    logic               dwell_clr, dwell_inc;
    logic               wait_clr, wait_inc;

    logic [2:0]         lamps;
    phase_e             sampled;
    logic               stay_green;
    logic [7:1]         viol;
    err_code_e          first_err;

    sat_counter #(.WIDTH(DWELL_W)) u_dwell (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (dwell_clr),
        .inc_i   (dwell_inc),
        .count_o (dwell_q)
    );

    sat_counter #(.WIDTH(WAIT_W)) u_wait (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (wait_clr),
        .inc_i   (wait_inc),
        .count_o (wait_q)
    );

    always_comb begin
        lamps           = '0;
        lamps[LAMP_GRN] = mon.grn;
        lamps[LAMP_YLW] = mon.ylw;
        lamps[LAMP_RED] = mon.red;
        sampled         = lamp_to_phase(lamps);

        phase_d   = phase_q;
        checked_d = checked_q;
        dwell_clr = 1'b0;
        dwell_inc = 1'b0;
        viol      = '0;

        // checked_q=0 marks a phase adopted from SYNC: only ONEHOT/SEQ apply to it.
        if (phase_q == PH_SYNC) begin
            dwell_clr = 1'b1;
            if (sampled != PH_SYNC) begin
                phase_d   = sampled;
                checked_d = 1'b0;
                dwell_inc = 1'b1;
            end
        end else if (sampled == PH_SYNC) begin
            viol[ERR_ONEHOT] = 1'b1;
            phase_d          = PH_SYNC;
            dwell_clr        = 1'b1;
        end else if (sampled == phase_q) begin
            dwell_inc = 1'b1;
            if (checked_q && (phase_q == PH_YELLOW) && (dwell_q == YLW_MAX_C))
                viol[ERR_YLW_LONG] = 1'b1;
        end else begin
            if (sampled != legal_next(phase_q))
                viol[ERR_SEQ] = 1'b1;
            if (checked_q) begin
                if ((phase_q == PH_YELLOW) && (dwell_q < YLW_MIN_C))
                    viol[ERR_YLW_SHORT] = 1'b1;
                if ((phase_q == PH_RED) && (dwell_q < RED_MIN_C))
                    viol[ERR_RED_SHORT] = 1'b1;
                if ((phase_q == PH_GREEN) && !car_req_q && !mon.car)
                    viol[ERR_NOCAR] = 1'b1;
            end
            phase_d   = sampled;
            checked_d = 1'b1;
            dwell_clr = 1'b1;
            dwell_inc = 1'b1;
        end

        // WAIT reads 0 on the request edge and counts only while the request is held in green.
        stay_green = (phase_q == PH_GREEN) && (phase_d == PH_GREEN);
        car_req_d  = (phase_d == PH_GREEN) && ((stay_green && car_req_q) || mon.car);
        wait_inc   = stay_green && car_req_q;
        wait_clr   = !wait_inc;
        if (checked_q && wait_inc && (wait_q == STARVE_AT))
            viol[ERR_STARVE] = 1'b1;

        first_err = ERR_NONE;
        for (int unsigned i = 1; i <= 7; i++) begin
            if (viol[i] && (first_err == ERR_NONE))
                first_err = err_code_e'(3'(i));
        end

        err_pulse_d = |viol;
        err_d       = err_q | (|viol);
        err_code_d  = (err_code_q == ERR_NONE) ? first_err : err_code_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q     <= PH_SYNC;
            checked_q   <= 1'b0;
            car_req_q   <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_pulse_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            checked_q   <= checked_d;
            car_req_q   <= car_req_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign mon.phase     = phase_q;
    assign mon.dwell     = dwell_q;
    assign mon.err       = err_q;
    assign mon.err_code  = err_code_q;
    assign mon.err_pulse = err_pulse_q;
endmodule

// File: tb/tb_fsm_light_monitor.sv
// Scoreboard bench for fsm_light_monitor: a run-length/timestamp reference model
// predicts every cycle's outputs; a monitor process compares them.
module tb_fsm_light_monitor;
    localparam int YMIN = 3;
    localparam int YMAX = 4;
    localparam int RMIN = 5;
    localparam int CTO  = 25;

    typedef struct {
        int phase;
        int dwell;
        int err;
        int code;
        int pulse;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fsm_light_monitor_if bus ();

    fsm_light_monitor #(
        .YLW_MIN     (YMIN),
        .YLW_MAX     (YMAX),
        .RED_MIN     (RMIN),
        .CAR_TIMEOUT (CTO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .mon   (bus)
    );

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   sample_n = 0;

    // Reference model: current phase (0 = none), run length, whether the run
    // began after a resync, and the cycle stamp of the pending car request.
    int m_cur    = 0;
    int m_run    = 0;
    bit m_fresh  = 1'b1;
    int m_req_at = -1;
    int m_cyc    = 0;
    int m_err    = 0;
    int m_code   = 0;

    task automatic model_step(input bit r, input bit [2:0] lamps, input bit car,
                              output exp_t e);
        int nxt;
        int hit;
        hit = 0;
        if (r) begin
            m_cur = 0; m_run = 0; m_fresh = 1'b1; m_req_at = -1;
            m_err = 0; m_code = 0;
        end else begin
            m_cyc++;
            case (lamps)
                3'b100:  nxt = 1;
                3'b010:  nxt = 2;
                3'b001:  nxt = 3;
                default: nxt = -1;
            endcase
            if (m_cur == 0) begin
                m_run = 0;
                if (nxt > 0) begin
                    m_cur = nxt; m_run = 1; m_fresh = 1'b1;
                    m_req_at = (nxt == 1 && car) ? m_cyc : -1;
                end
            end else if (nxt < 0) begin
                hit = 1;
                m_cur = 0; m_run = 0; m_req_at = -1;
            end else if (nxt == m_cur) begin
                m_run = (m_run < 255) ? m_run + 1 : 255;
                if (m_cur == 2 && !m_fresh && m_run == YMAX + 1) hit = 4;
                if (m_cur == 1) begin
                    if (m_req_at < 0 && car) m_req_at = m_cyc;
                    if (!m_fresh && m_req_at >= 0 && (m_cyc - m_req_at) == CTO) hit = 7;
                end
            end else begin
                int codes[$];
                if (nxt != (m_cur % 3) + 1) codes.push_back(2);
                if (!m_fresh) begin
                    if (m_cur == 2 && m_run < YMIN) codes.push_back(3);
                    if (m_cur == 3 && m_run < RMIN) codes.push_back(5);
                    if (m_cur == 1 && m_req_at < 0 && !car) codes.push_back(6);
                end
                if (codes.size() > 0) hit = codes.min()[0];
                m_cur = nxt; m_run = 1; m_fresh = 1'b0;
                m_req_at = (nxt == 1 && car) ? m_cyc : -1;
            end
            if (hit != 0) begin
                m_err = 1;
                if (m_code == 0) m_code = hit;
            end
        end
        e.phase = m_cur;
        e.dwell = m_run;
        e.err   = m_err;
        e.code  = m_code;
        e.pulse = (r || hit == 0) ? 0 : 1;
    endtask

    task automatic drive(input bit r, input bit [2:0] lamps, input bit car);
        exp_t e;
        @(negedge clk);
        rst     = r;
        bus.grn = lamps[2];
        bus.ylw = lamps[1];
        bus.red = lamps[0];
        bus.car = car;
        model_step(r, lamps, car, e);
        exp_q.push_back(e);
    endtask

    task automatic run_phase(input bit [2:0] lamps, input int n, input int car_at);
        for (int i = 0; i < n; i++) drive(1'b0, lamps, (i == car_at));
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s sample=%0d got=%0d expected=%0d", name, sample_n, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                sample_n++;
                check("phase",     int'(bus.phase),     e.phase);
                check("dwell",     int'(bus.dwell),     e.dwell);
                check("err",       int'(bus.err),       e.err);
                check("err_code",  int'(bus.err_code),  e.code);
                check("err_pulse", int'(bus.err_pulse), e.pulse);
            end
        end
    end

    localparam bit [2:0] G = 3'b100;
    localparam bit [2:0] Y = 3'b010;
    localparam bit [2:0] R = 3'b001;

    initial begin : stimulus
        int cur;
        int nxt;
        int len;
        int pick;
        bit [2:0] bad;
        bit [2:0] bad_set[5];
        bad_set[0] = 3'b000; bad_set[1] = 3'b011; bad_set[2] = 3'b101;
        bad_set[3] = 3'b110; bad_set[4] = 3'b111;
        bus.grn = 1'b0; bus.ylw = 1'b0; bus.red = 1'b0; bus.car = 1'b0;

        // Clean cycle: no errors expected.
        drive(1'b1, 3'b000, 1'b0);
        run_phase(R, 6, -1); run_phase(G, 30, 10); run_phase(Y, 3, -1); run_phase(R, 6, -1);
        // Short yellow, then short red: code stays YLW_SHORT.
        run_phase(G, 4, 1); run_phase(Y, 2, -1); run_phase(R, 2, -1); run_phase(G, 3, 0);
        // Two lamps at once, then resync straight into yellow.
        drive(1'b1, 3'b000, 1'b0);
        run_phase(R, 6, -1); run_phase(G, 10, 2); run_phase(3'b101, 1, -1);
        run_phase(Y, 4, -1); run_phase(R, 6, -1);
        // Starvation: request at green cycle 5, green held 40.
        drive(1'b1, 3'b000, 1'b0);
        run_phase(R, 6, -1); run_phase(G, 40, 5); run_phase(Y, 3, -1); run_phase(R, 6, -1);
        // NOCAR, then a direct green-to-red.
        drive(1'b1, 3'b000, 1'b0);
        run_phase(R, 6, -1); run_phase(G, 5, -1); run_phase(Y, 3, -1); run_phase(R, 6, -1);
        run_phase(G, 5, 1); run_phase(R, 3, -1);
        // Reset in yellow, then the reset path yellow-to-red.
        drive(1'b1, 3'b000, 1'b0);
        run_phase(R, 6, -1); run_phase(G, 5, 1); run_phase(Y, 2, -1);
        drive(1'b1, Y, 1'b0);
        run_phase(Y, 1, -1); run_phase(R, 6, -1);
        // Dwell saturation on a very long green.
        run_phase(G, 300, 3); run_phase(Y, 5, -1);

        // Randomised traffic: mostly legal loops with injected faults and resets.
        cur = 3;
        for (int k = 0; k < 400; k++) begin
            pick = $urandom_range(0, 99);
            if (pick < 3) begin
                drive(1'b1, 3'b000, 1'b0);
                continue;
            end else if (pick < 9) begin
                bad = bad_set[$urandom_range(0, 4)];
                run_phase(bad, $urandom_range(1, 2), -1);
                continue;
            end else if (pick < 18) begin
                nxt = $urandom_range(1, 3);
            end else begin
                nxt = (cur % 3) + 1;
            end
            cur = nxt;
            len = (cur == 1) ? $urandom_range(1, 35) : $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                drive(1'b0, (cur == 1) ? G : (cur == 2) ? Y : R,
                      ($urandom_range(0, 9) == 0));
            end
        end

        begin : drain
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            @(posedge clk);
            #2;
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL drain got=%0d pending expected=0", exp_q.size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
